if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ============================================================================
// if_stage_if : instruction-memory request/response bundle for the fetch stage
// rev 1.0
// ============================================================================
`default_nettype none

interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// if_stage : pipelined instruction fetch with IF/ID register, HALT detection
// and optional perf counters (define FETCH_PERF_CNT_EN).  rev 1.0
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        stall,
  input  wire logic        flush,
  input  wire logic [31:0] branch_target,
  if_stage_if.master       imem,
  output logic [31:0]      PC,
  output logic [31:0]      instr,
  output logic             valid,
  output logic             halted,
  output logic [31:0]      fetch_count,
  output logic [31:0]      bubble_count
);

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;

  // A capture happens only when the fetch side is live and nothing overrides it.
  logic capture_w;
  assign capture_w = !flush && !stall && (state_q == FETCH) && imem.imem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      pc_q       <= 32'h0000_0000;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else if (flush) begin
      state_q    <= FETCH;
      fetch_pc_q <= branch_target;
      pc_q       <= 32'h0000_0000;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else if (stall) begin
      state_q    <= state_q;
    end else if (capture_w) begin
      pc_q       <= fetch_pc_q;
      instr_q    <= imem.imem_rdata;
      valid_q    <= 1'b1;
      fetch_pc_q <= fetch_pc_q + 32'd4;
      if (imem.imem_rdata == HALT_INSTR) begin
        state_q  <= HALTED;
      end
    end else begin
      pc_q       <= 32'h0000_0000;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = fetch_pc_q;
  assign PC             = pc_q;
  assign instr          = instr_q;
  assign valid          = valid_q;
  assign halted         = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic        bubble_w;
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;

  // Flush always writes a bubble, even while decode is stalling.
  assign bubble_w = flush || (!stall && !capture_w);

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (capture_w && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (bubble_w && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt_q  <= 32'h0000_0000;
      bubble_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`else
  assign fetch_count  = 32'h0000_0000;
  assign bubble_count = 32'h0000_0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : randomized + directed bench for if_stage against a rule model
// rev 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;
  localparam logic [31:0] C_HALT     = 32'h0000_0073;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] PC, instr, fetch_count, bubble_count;
  logic        valid, halted;

  if_stage_if imem ();

  if_stage #(
    .RESET_PC   (C_RESET_PC),
    .NOP_INSTR  (C_NOP),
    .HALT_INSTR (C_HALT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem          (imem.master),
    .PC            (PC),
    .instr         (instr),
    .valid         (valid),
    .halted        (halted),
    .fetch_count   (fetch_count),
    .bubble_count  (bubble_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural view of the fetch stage.
  logic        m_halted;
  logic [31:0] m_fpc, m_pc, m_instr;
  logic        m_valid;
  longint      m_fetches, m_bubbles;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic check_outputs(input string where);
    chk({where, "_pc"},     PC,              m_pc);
    chk({where, "_instr"},  instr,           m_instr);
    chk({where, "_valid"},  {31'b0, valid},  {31'b0, m_valid});
    chk({where, "_halted"}, {31'b0, halted}, {31'b0, m_halted});
    chk({where, "_addr"},   imem.imem_addr,  m_fpc);
    chk({where, "_req"},    {31'b0, imem.imem_req}, {31'b0, !m_halted});
`ifdef FETCH_PERF_CNT_EN
    chk({where, "_fcnt"},   fetch_count,     sat32(m_fetches));
    chk({where, "_bcnt"},   bubble_count,    sat32(m_bubbles));
`else
    chk({where, "_fcnt"},   fetch_count,     32'h0);
    chk({where, "_bcnt"},   bubble_count,    32'h0);
`endif
  endtask

  task automatic model_reset();
    m_halted  = 1'b0;
    m_fpc     = C_RESET_PC;
    m_pc      = 32'h0;
    m_instr   = C_NOP;
    m_valid   = 1'b0;
    m_fetches = 0;
    m_bubbles = 0;
  endtask

  // Called at a negedge; asserts reset asynchronously mid-cycle, releases at next negedge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Called at a negedge: drive one cycle of stimulus, advance the model, check.
  task automatic step(input logic st, input logic fl, input logic [31:0] bt,
                      input logic rdy, input logic [31:0] rd);
    stall = st;
    flush = fl;
    branch_target = bt;
    imem.imem_ready = rdy;
    imem.imem_rdata = rd;
    #1;
    chk("pre_addr", imem.imem_addr, m_fpc);
    chk("pre_req",  {31'b0, imem.imem_req}, {31'b0, !m_halted});
    @(posedge clock);
    if (fl) begin
      m_fpc = bt; m_pc = 0; m_instr = C_NOP; m_valid = 0; m_halted = 0;
      m_bubbles++;
    end else if (st) begin
      // everything holds
    end else if (!m_halted && rdy) begin
      m_pc = m_fpc; m_instr = rd; m_valid = 1;
      m_fpc = m_fpc + 32'd4;
      m_fetches++;
      if (rd == C_HALT) m_halted = 1;
    end else begin
      m_pc = 0; m_instr = C_NOP; m_valid = 0;
      m_bubbles++;
    end
    #1;
    check_outputs("cyc");
    @(negedge clock);
  endtask

  task automatic fetch(input logic [31:0] rd);
    step(1'b0, 1'b0, 32'h0, 1'b1, rd);
  endtask

  initial begin
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 32'h0;
    model_reset();
    @(negedge clock);
    do_reset();

    // Two back-to-back fetches from reset.
    fetch(32'h00A0_0093);
    chk("d33_pc0", PC, 32'h0);
    chk("d33_i0",  instr, 32'h00A0_0093);
    fetch(32'h0010_8113);
    chk("d33_pc1", PC, 32'h4);
    chk("d33_a8",  imem.imem_addr, 32'h8);

    // Stall discards responses and holds everything.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, $urandom);
    chk("d34_pc",  PC, 32'h4);
    chk("d34_a",   imem.imem_addr, 32'h8);
    fetch(32'h0020_0193);
    chk("d34_pc8", PC, 32'h8);

    // Flush wins over stall.
    step(1'b1, 1'b1, 32'h100, 1'b1, 32'hDEAD_BEEF);
    chk("d35_v",   {31'b0, valid}, 32'h0);
    chk("d35_i",   instr, 32'h13);
    chk("d35_a",   imem.imem_addr, 32'h100);

    // HALT at PC 0xC, then flush out of HALTED.
    do_reset();
    fetch(32'h1); fetch(32'h2); fetch(32'h3);
    fetch(C_HALT);
    chk("d36_pc",  PC, 32'hC);
    chk("d36_h",   {31'b0, halted}, 32'h1);
    chk("d36_req", {31'b0, imem.imem_req}, 32'h0);
    for (int i = 0; i < 3; i++) fetch($urandom);
    chk("d36_v0",  {31'b0, valid}, 32'h0);
    step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("d36_h0",  {31'b0, halted}, 32'h0);
    chk("d36_a",   imem.imem_addr, 32'h40);

    // Counter scenario and address wrap via unaligned-safe flush load.
    do_reset();
    for (int i = 0; i < 5; i++) fetch(32'h1000 + i);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("d37_fc",  fetch_count, 32'd5);
    chk("d37_bc",  bubble_count, 32'd3);
`endif
    fetch(32'h5);
    chk("d37_wrap", imem.imem_addr, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0123, 1'b0, 32'h0);
    chk("d28_unal", imem.imem_addr, 32'h0000_0123);

    // Randomized traffic, including mid-stall / mid-halt resets.
    for (int i = 0; i < 600; i++) begin
      logic        st, fl, rdy;
      logic [31:0] bt, rd;
      st  = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       bt = 32'hFFFF_FFF8 + {$urandom_range(0, 7)};
        default: bt = $urandom;
      endcase
      rd = ($urandom_range(0, 11) == 0) ? C_HALT : $urandom;
      if ($urandom_range(0, 59) == 0) do_reset();
      step(st, fl, bt, rdy, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
